// File: rtl/par2srl.sv
// par2srl: parallel-to-serial transmitter with valid/sof/eof frame markers; ports clk, rst, par/par_vld/par_rdy in, srl_en stall, srl/srl_vld/srl_sof/srl_eof out; `PAR2SRL_PARITY_EN appends an even-parity bit
module par2srl #(
  parameter int WIDTH = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] par,
  input  logic             par_vld,
  output logic             par_rdy,
  input  logic             srl_en,
  output logic             srl,
  output logic             srl_vld,
  output logic             srl_sof,
  output logic             srl_eof
);
`ifdef PAR2SRL_PARITY_EN
  localparam int L = WIDTH + 1;
`else
  localparam int L = WIDTH;
`endif
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] LAST = CW'(L - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_nx;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic srl_d, vld_d, sof_d, eof_d, acc, last, nxt_bit;
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST != 0 ? w[WIDTH-1] : w[0];
  endfunction
  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
    return MSB_FIRST != 0 ? w << 1 : w >> 1;
  endfunction
  assign last    = state_q == SHIFT && cnt_q == LAST;
  assign par_rdy = !rst && srl_en && (state_q == IDLE || last);
  assign acc     = par_vld && par_rdy;
  assign cnt_nx  = cnt_q + CW'(1);
`ifdef PAR2SRL_PARITY_EN
  logic pty_q;
  assign nxt_bit = cnt_nx == CW'(WIDTH) ? pty_q : head(sr_q);
  always_ff @(posedge clk)
    if (rst) pty_q <= 1'b0;
    else if (acc) pty_q <= ^par;
`else
  assign nxt_bit = head(sr_q);
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    srl_d   = srl;
    vld_d   = srl_vld;
    sof_d   = srl_sof;
    eof_d   = srl_eof;
    if (acc) begin
      state_d = SHIFT;
      cnt_d   = '0;
      sr_d    = adv(par);
      srl_d   = head(par);
      vld_d   = 1'b1;
      sof_d   = 1'b1;
      eof_d   = 1'b0;
    end else if (srl_en && last) begin
      state_d = IDLE;
      cnt_d   = '0;
      srl_d   = 1'b0;
      vld_d   = 1'b0;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
    end else if (srl_en && state_q == SHIFT) begin
      cnt_d   = cnt_nx;
      sr_d    = adv(sr_q);
      srl_d   = nxt_bit;
      sof_d   = 1'b0;
      eof_d   = cnt_nx == LAST;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      srl     <= 1'b0;
      srl_vld <= 1'b0;
      srl_sof <= 1'b0;
      srl_eof <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      srl     <= srl_d;
      srl_vld <= vld_d;
      srl_sof <= sof_d;
      srl_eof <= eof_d;
    end
endmodule

// File: tb/tb_par2srl.sv
// tb_par2srl: directed checks of par2srl (LSB-first and MSB-first instances)
module tb_par2srl;
  logic clk = 0, rst = 1, par_vld = 0, srl_en = 1;
  logic [3:0] par = '0;
  logic par_rdy, srl, srl_vld, srl_sof, srl_eof;
  logic m_rdy, m_srl, m_vld, m_sof, m_eof;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  par2srl #(.WIDTH(4), .MSB_FIRST(0)) u_dut (.clk(clk), .rst(rst), .par(par), .par_vld(par_vld),
    .par_rdy(par_rdy), .srl_en(srl_en), .srl(srl), .srl_vld(srl_vld), .srl_sof(srl_sof), .srl_eof(srl_eof));
  par2srl #(.WIDTH(4), .MSB_FIRST(1)) u_msb (.clk(clk), .rst(rst), .par(par), .par_vld(par_vld),
    .par_rdy(m_rdy), .srl_en(srl_en), .srl(m_srl), .srl_vld(m_vld), .srl_sof(m_sof), .srl_eof(m_eof));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask
  initial begin
    logic [0:7] e;
    #1;
    chk("rst_rdy", par_rdy, 1'b0);
    step();
    step();
    chk("rst_srl", srl, 1'b0);
    chk("rst_vld", srl_vld, 1'b0);
    chk("rst_sof", srl_sof, 1'b0);
    chk("rst_eof", srl_eof, 1'b0);
    rst = 0;
    #1;
    chk("idle_rdy", par_rdy, 1'b1);
`ifdef PAR2SRL_PARITY_EN
    e = 8'b1110_1000;
    par = 4'b0111;
    par_vld = 1;
    for (int c = 1; c <= 5; c++) begin
      step();
      par_vld = 0;
      chk($sformatf("pty_srl%0d", c), srl, e[c-1]);
      chk($sformatf("pty_vld%0d", c), srl_vld, 1'b1);
      chk($sformatf("pty_sof%0d", c), srl_sof, c == 1);
      chk($sformatf("pty_eof%0d", c), srl_eof, c == 5);
      chk($sformatf("pty_rdy%0d", c), par_rdy, c == 5);
    end
    step();
    chk("pty_end_vld", srl_vld, 1'b0);
`else
    e = 8'b1101_0000;
    par = 4'b1011;
    par_vld = 1;
    for (int c = 1; c <= 4; c++) begin
      step();
      par_vld = 0;
      chk($sformatf("one_srl%0d", c), srl, e[c-1]);
      chk($sformatf("one_vld%0d", c), srl_vld, 1'b1);
      chk($sformatf("one_sof%0d", c), srl_sof, c == 1);
      chk($sformatf("one_eof%0d", c), srl_eof, c == 4);
      chk($sformatf("one_rdy%0d", c), par_rdy, c == 4);
    end
    step();
    chk("one_end_vld", srl_vld, 1'b0);
    chk("one_end_srl", srl, 1'b0);
    chk("one_end_eof", srl_eof, 1'b0);
    e = 8'b0101_1010;
    par = 4'hA;
    par_vld = 1;
    chk("b2b_rdy0", par_rdy, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) par = 4'h5;
      if (c == 5) par_vld = 0;
      chk($sformatf("b2b_srl%0d", c), srl, e[c-1]);
      chk($sformatf("b2b_vld%0d", c), srl_vld, 1'b1);
      chk($sformatf("b2b_sof%0d", c), srl_sof, c == 1 || c == 5);
      chk($sformatf("b2b_eof%0d", c), srl_eof, c == 4 || c == 8);
      chk($sformatf("b2b_rdy%0d", c), par_rdy, c == 4 || c == 8);
    end
    step();
    chk("b2b_end_vld", srl_vld, 1'b0);
    e = 8'b0111_1000;
    par = 4'b0110;
    par_vld = 1;
    for (int c = 1; c <= 6; c++) begin
      step();
      par_vld = 0;
      if (c == 2) srl_en = 0;
      if (c == 4) srl_en = 1;
      #1;
      chk($sformatf("stl_srl%0d", c), srl, e[c-1]);
      chk($sformatf("stl_vld%0d", c), srl_vld, 1'b1);
      chk($sformatf("stl_sof%0d", c), srl_sof, c == 1);
      chk($sformatf("stl_eof%0d", c), srl_eof, c == 6);
      chk($sformatf("stl_rdy%0d", c), par_rdy, c == 6);
    end
    step();
    chk("stl_end_vld", srl_vld, 1'b0);
    e = 8'b1000_0001;
    par = 4'b1000;
    par_vld = 1;
    for (int c = 1; c <= 4; c++) begin
      step();
      par_vld = 0;
      chk($sformatf("msb_srl%0d", c), m_srl, e[c-1]);
      chk($sformatf("msb_sof%0d", c), m_sof, c == 1);
      chk($sformatf("msb_eof%0d", c), m_eof, c == 4);
      chk($sformatf("lsb_srl%0d", c), srl, e[c+3]);
    end
    step();
    chk("msb_end_vld", m_vld, 1'b0);
    par = 4'hF;
    par_vld = 1;
    step();
    par_vld = 0;
    chk("rmf_srl1", srl, 1'b1);
    step();
    rst = 1;
    #1;
    chk("rmf_rdy_rst", par_rdy, 1'b0);
    step();
    rst = 0;
    #1;
    chk("rmf_srl3", srl, 1'b0);
    chk("rmf_vld3", srl_vld, 1'b0);
    chk("rmf_sof3", srl_sof, 1'b0);
    chk("rmf_rdy3", par_rdy, 1'b1);
    par = 4'h3;
    par_vld = 1;
    step();
    par_vld = 0;
    chk("rmf_new_sof", srl_sof, 1'b1);
    chk("rmf_new_srl", srl, 1'b1);
    chk("rmf_new_vld", srl_vld, 1'b1);
    chk("rmf_new_eof", srl_eof, 1'b0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/par2srl.md
Name: par2srl

Overview:
- Parallel-to-serial transmitter; the counterpart of the team's serial-to-parallel receiver.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per enabled clock on a single serial line.
- Drives frame markers (valid, start, end) so a downstream deserializer or link stage can align to word boundaries.
- Supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..32.
- MSB_FIRST, 0, 0 = bit 0 sent first; 1 = bit WIDTH-1 sent first.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- par  input  WIDTH  parallel word; sampled only on handshake accept.
- par_vld  input  1  par holds a valid word.
- par_rdy  output  1  block can accept a word this cycle.
- srl_en  input  1  shift enable; 0 stalls the block.
- srl  output  1  serial data bit.
- srl_vld  output  1  srl carries a frame bit this cycle.
- srl_sof  output  1  first bit of a frame.
- srl_eof  output  1  last bit of a frame.

Behaviour:
- Reset and clocking: one clock (clk); reset is synchronous and active-high (rst).
- While rst=1 at a rising edge:
  - state<=IDLE, bit counter<=0, shift register<=0.
  - srl, srl_vld, srl_sof, srl_eof <= 0.
- par_rdy is combinational and is 0 whenever rst=1.
- Frame length: L = WIDTH, or WIDTH+1 with the optional feature.
- States:
  - IDLE: srl_vld=0, srl=0.
  - SHIFT: bit counter runs 0..L-1.
- par_rdy rule: par_rdy = !rst && srl_en && (state==IDLE || (state==SHIFT && cnt==L-1)).
- Accept occurs when par_vld && par_rdy at a rising edge. On accept:
  - par is captured into the shift register.
  - cnt<=0 and state<=SHIFT.
  - par may change freely after accept.
- Latency: first serial bit is registered on the edge of accept, so it is visible the cycle after accept.
- SHIFT, srl_en=1, each edge:
  - present next bit and increment cnt.
  - srl_sof=1 only when cnt==0.
  - srl_eof=1 only when cnt==L-1.
  - srl_vld=1 throughout.
- Bit order:
  - MSB_FIRST=0: bit k of the word is driven on cnt==k.
  - MSB_FIRST=1: bit WIDTH-1-k is driven on cnt==k.
- End of frame (edge at cnt==L-1):
  - Accept present: the new word's first bit follows immediately with srl_sof=1 and no gap.
  - No accept: state<=IDLE; srl_vld, srl, srl_sof and srl_eof return to 0.
- Stall (srl_en=0): all registers hold, including srl/srl_vld/srl_sof/srl_eof. par_rdy=0, so no accept can occur while stalled.
- par_vld=1 with par_rdy=0: no capture. The upstream source must hold par and par_vld.
- Reset mid-frame: the frame is aborted, and outputs are 0 the cycle after the reset edge. A partial frame never resumes; the next accept starts a fresh frame with srl_sof.
- srl_sof and srl_eof are never both 1 (L≥2).
- Counter width: clog2(L+1) bits. cnt never exceeds L-1.

Optional Feature:
- Macro: PAR2SRL_PARITY_EN.
- Defined:
  - L = WIDTH+1.
  - After the last data bit, one even-parity bit is sent (XOR of all WIDTH captured bits), with srl_eof=1 on the parity bit only.
  - par_rdy reopens on the parity-bit cycle.
- Undefined:
  - L = WIDTH; no parity logic is synthesized.
  - srl_eof asserts on the last data bit.

Test Plan:
- Single word: WIDTH=4, MSB_FIRST=0, srl_en=1, par=4'b1011 accepted at cycle 0 -> srl=1,1,0,1 on cycles 1-4, srl_vld=1 on cycles 1-4, srl_sof on cycle 1, srl_eof on cycle 4, srl_vld=0 on cycle 5.
- Back-to-back: par_vld held high with 4'hA then 4'h5 -> par_rdy=1 at cycles 0 and 4; srl=0,1,0,1,1,0,1,0 on cycles 1-8 with no gap; srl_sof on cycles 1 and 5.
- Stall: srl_en=0 on cycles 2-3 during word 4'b0110 -> outputs frozen at bit-1 value (1) for two extra cycles; frame completes on cycle 6; par_rdy=0 on cycles 2-3.
- MSB_FIRST=1: par=4'b1000 -> srl=1,0,0,0 on cycles 1-4.
- Reset mid-frame: rst=1 at cycle 2 of word 4'hF -> srl/srl_vld=0 from cycle 3; par_rdy=1 once rst=0; next word starts with srl_sof.
- Parity (macro defined): par=4'b0111 -> srl=1,1,1,0,1 on cycles 1-5 (parity bit 1), srl_eof on cycle 5 only.
